rsa_exp_ctrl: RTL and testbench

RSA_EXP_CTRL -- requirements
Module: rsa_exp_ctrl

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_exp_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared constants and controller state encoding for the RSA exponentiation path
package rsa_pkg;

    // Default operand width for a, e, n and every intermediate result.
    localparam int W = 256;

    // Initial accumulator value. The accumulator stays in the normal domain
    // (it is always multiplied by a Montgomery-form operand), so this is a
    // plain 1 rather than R mod n.
    localparam int MONT_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRANS  = 3'd1,
        S_MULT   = 3'd2,
        S_SQUARE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/rsa_exp_ctrl.sv
// rtl/rsa_exp_ctrl.sv - right-to-left binary modular exponentiation sequencer (a^e mod n)
//
// Drives one Montgomery pre-transform unit and one shared Montgomery product unit.
// Build option: RSA_EXP_EARLY_EXIT_EN stops after the highest set exponent bit.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_start, i_a, i_e, i_n       start pulse and operands (captured in S_IDLE only)
//   o_a_pow, o_finished          result (held until next completion), one-cycle done pulse
//   o_trans_*, i_trans_*         pre-transform handshake: returns a*2^W mod n
//   o_mult_*, i_mult_*           product handshake: returns a*b*2^-W mod n
module rsa_exp_ctrl #(
    parameter int W = rsa_pkg::W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_e,
    input  logic [W-1:0] i_n,
    output logic [W-1:0] o_a_pow,
    output logic         o_finished,
    output logic         o_trans_start,
    output logic [W-1:0] o_trans_a,
    output logic [W-1:0] o_trans_n,
    input  logic         i_trans_done,
    input  logic [W-1:0] i_trans_result,
    output logic         o_mult_start,
    output logic [W-1:0] o_mult_a,
    output logic [W-1:0] o_mult_b,
    output logic [W-1:0] o_mult_n,
    input  logic         i_mult_done,
    input  logic [W-1:0] i_mult_result
);

    import rsa_pkg::state_t;
    import rsa_pkg::S_IDLE;
    import rsa_pkg::S_TRANS;
    import rsa_pkg::S_MULT;
    import rsa_pkg::S_SQUARE;
    import rsa_pkg::S_DONE;
    import rsa_pkg::MONT_ONE;

    // One extra bit so k+1 can represent W without wrapping.
    localparam int KW = $clog2(W) + 1;

    state_t        r_state;
    state_t        w_next_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_e;
    logic [W-1:0]  r_n;
    logic [W-1:0]  r_y;
    logic [W-1:0]  r_m;
    logic [W-1:0]  r_a_pow;
    logic [KW-1:0] r_k;
    logic          r_trans_start;
    logic          r_mult_start;

    logic          w_trans_issue;
    logic          w_mult_issue;
    logic          w_trans_accept;
    logic          w_mult_accept;
    logic [KW-1:0] w_k_inc;
    logic          w_next_bit;
    logic          w_last_bit;
    logic          w_skip_all;

    assign w_k_inc    = r_k + KW'(1);
    // Exponent bit k+1; the shift yields zero once k+1 reaches W.
    assign w_next_bit = |(r_e & (W'(1) << w_k_inc));

`ifdef RSA_EXP_EARLY_EXIT_EN
    logic [W-1:0] w_e_rest;
    assign w_e_rest   = r_e >> w_k_inc;
    assign w_last_bit = (r_k == KW'(W - 1)) || (w_e_rest == '0);
    assign w_skip_all = (r_e == '0);
`else
    assign w_last_bit = (r_k == KW'(W - 1));
    assign w_skip_all = 1'b0;
`endif

    always_comb begin
        w_next_state   = r_state;
        w_trans_issue  = 1'b0;
        w_mult_issue   = 1'b0;
        w_trans_accept = 1'b0;
        w_mult_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state  = S_TRANS;
                    w_trans_issue = 1'b1;
                end
            end
            S_TRANS: begin
                // A done coinciding with our own start pulse is stale.
                if (i_trans_done && !r_trans_start) begin
                    w_trans_accept = 1'b1;
                    if (w_skip_all) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = r_e[0] ? S_MULT : S_SQUARE;
                        w_mult_issue = 1'b1;
                    end
                end
            end
            S_MULT: begin
                if (i_mult_done && !r_mult_start) begin
                    w_mult_accept = 1'b1;
                    w_next_state  = S_SQUARE;
                    w_mult_issue  = 1'b1;
                end
            end
            S_SQUARE: begin
                if (i_mult_done && !r_mult_start) begin
                    w_mult_accept = 1'b1;
                    if (w_last_bit) begin
                        w_next_state = S_DONE;
                    end else begin
                        // Square-to-square is a re-entry, so the start pulse
                        // comes from this issue flag, not a state change.
                        w_next_state = w_next_bit ? S_MULT : S_SQUARE;
                        w_mult_issue = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= S_IDLE;
            r_a           <= '0;
            r_e           <= '0;
            r_n           <= '0;
            r_y           <= '0;
            r_m           <= '0;
            r_k           <= '0;
            r_a_pow       <= '0;
            r_trans_start <= 1'b0;
            r_mult_start  <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_trans_start <= w_trans_issue;
            r_mult_start  <= w_mult_issue;

            if (r_state == S_IDLE && i_start) begin
                r_a <= i_a;
                r_e <= i_e;
                r_n <= i_n;
            end

            if (w_trans_accept) begin
                r_y <= i_trans_result;
                r_m <= W'(MONT_ONE);
                r_k <= '0;
            end

            if (w_mult_accept && r_state == S_MULT) begin
                r_m <= i_mult_result;
            end

            if (w_mult_accept && r_state == S_SQUARE) begin
                r_y <= i_mult_result;
                if (!w_last_bit) begin
                    r_k <= w_k_inc;
                end
            end

            // Result is latched on entry to S_DONE so it is valid during the
            // o_finished cycle; m is unchanged on that transition except when
            // the e = 0 shortcut leaves straight from S_TRANS.
            if (w_next_state == S_DONE && r_state != S_DONE) begin
                r_a_pow <= w_trans_accept ? W'(MONT_ONE) : r_m;
            end
        end
    end

    assign o_a_pow       = r_a_pow;
    assign o_finished    = (r_state == S_DONE);
    assign o_trans_start = r_trans_start;
    assign o_trans_a     = r_a;
    assign o_trans_n     = r_n;
    assign o_mult_start  = r_mult_start;
    // Operands come straight from m/y, which only change on an accepted done,
    // so they stay stable for the whole wait.
    assign o_mult_a      = (r_state == S_MULT) ? r_m : r_y;
    assign o_mult_b      = r_y;
    assign o_mult_n      = r_n;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb/tb_rsa_exp_ctrl.sv - directed self-checking bench for rsa_exp_ctrl with behavioural Montgomery units
module tb_rsa_exp_ctrl;

    localparam int W = 256;

`ifdef RSA_EXP_EARLY_EXIT_EN
    localparam int OPS_E7  = 6;
    localparam int OPS_E23 = 9;
    localparam int OPS_E0  = 0;
`else
    localparam int OPS_E7  = 259;
    localparam int OPS_E23 = 260;
    localparam int OPS_E0  = 256;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] e = '0;
    logic [W-1:0] n = '0;
    logic [W-1:0] o_a_pow;
    logic         o_finished;
    logic         o_trans_start;
    logic [W-1:0] o_trans_a;
    logic [W-1:0] o_trans_n;
    logic         trans_done_m;
    logic [W-1:0] trans_result;
    logic         o_mult_start;
    logic [W-1:0] o_mult_a;
    logic [W-1:0] o_mult_b;
    logic [W-1:0] o_mult_n;
    logic         mult_done_m;
    logic [W-1:0] mult_result;
    logic         stray_done = 1'b0;
    wire          w_trans_done = trans_done_m | stray_done;
    wire          w_mult_done  = mult_done_m | stray_done;

    int n_checks = 0;
    int n_errors = 0;
    int mult_lat = 1;
    int trans_lat = 2;
    int cnt_mult = 0;
    int cnt_trans = 0;
    int cnt_fin = 0;
    int cnt_both = 0;

    always #5 clk = ~clk;

    rsa_exp_ctrl #(.W(W)) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_start        (start),
        .i_a            (a),
        .i_e            (e),
        .i_n            (n),
        .o_a_pow        (o_a_pow),
        .o_finished     (o_finished),
        .o_trans_start  (o_trans_start),
        .o_trans_a      (o_trans_a),
        .o_trans_n      (o_trans_n),
        .i_trans_done   (w_trans_done),
        .i_trans_result (trans_result),
        .o_mult_start   (o_mult_start),
        .o_mult_a       (o_mult_a),
        .o_mult_b       (o_mult_b),
        .o_mult_n       (o_mult_n),
        .i_mult_done    (w_mult_done),
        .i_mult_result  (mult_result)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // x*y*2^-W mod m: reduce the product, then halve modulo m W times.
    function automatic logic [W-1:0] mont_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic [W-1:0] m);
        logic [2*W-1:0] t;
        logic [W:0]     r;
        t = ({{W{1'b0}}, x} * {{W{1'b0}}, y}) % {{W{1'b0}}, m};
        r = {1'b0, t[W-1:0]};
        for (int i = 0; i < W; i++) begin
            if (r[0]) r = (r + {1'b0, m}) >> 1;
            else      r = r >> 1;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] mont_trans(input logic [W-1:0] x, input logic [W-1:0] m);
        logic [2*W-1:0] t;
        t = {x, {W{1'b0}}} % {{W{1'b0}}, m};
        return t[W-1:0];
    endfunction

    initial begin : mult_model
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rn;
        int           lat;
        bit           aborted;
        mult_done_m = 1'b0;
        mult_result = '0;
        forever begin
            if (rst_n && o_mult_start) begin
                ra = o_mult_a; rb = o_mult_b; rn = o_mult_n;
                lat = mult_lat;
                aborted = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk); #1;
                    if (!rst_n) begin aborted = 1'b1; break; end
                end
                if (!aborted) begin
                    mult_result = mont_prod(ra, rb, rn);
                    mult_done_m = 1'b1;
                    @(posedge clk); #1;
                    mult_done_m = 1'b0;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    initial begin : trans_model
        logic [W-1:0] ta;
        logic [W-1:0] tn;
        int           lat;
        bit           aborted;
        trans_done_m = 1'b0;
        trans_result = '0;
        forever begin
            if (rst_n && o_trans_start) begin
                ta = o_trans_a; tn = o_trans_n;
                lat = trans_lat;
                aborted = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk); #1;
                    if (!rst_n) begin aborted = 1'b1; break; end
                end
                if (!aborted) begin
                    trans_result = mont_trans(ta, tn);
                    trans_done_m = 1'b1;
                    @(posedge clk); #1;
                    trans_done_m = 1'b0;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (o_mult_start) cnt_mult++;
            if (o_trans_start) cnt_trans++;
            if (o_finished) cnt_fin++;
            if (o_mult_start && o_trans_start) cnt_both++;
        end
    end

    task automatic clear_counts();
        cnt_mult = 0; cnt_trans = 0; cnt_fin = 0; cnt_both = 0;
    endtask

    task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] te, input logic [W-1:0] tn);
        @(negedge clk);
        a = ta; e = te; n = tn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input logic [W-1:0] exp);
        int cyc;
        cyc = 0;
        while (!o_finished && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_finished"}, W'(o_finished), W'(1));
        check_eq({tag, "_pow"}, o_a_pow, exp);
    endtask

    task automatic post_checks(input string tag, input logic [W-1:0] exp, input int ops);
        repeat (10) @(negedge clk);
        check_eq({tag, "_fin_count"}, W'(cnt_fin), W'(1));
        check_eq({tag, "_mult_starts"}, W'(cnt_mult), W'(ops));
        check_eq({tag, "_trans_starts"}, W'(cnt_trans), W'(1));
        check_eq({tag, "_start_overlap"}, W'(cnt_both), W'(0));
        check_eq({tag, "_pow_hold"}, o_a_pow, exp);
    endtask

    task automatic wait_mult_start(input string tag);
        int cyc;
        cyc = 0;
        while (!o_mult_start && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_mult_seen"}, W'(o_mult_start), W'(1));
    endtask

    initial begin : stimulus
        logic [W-1:0] ha;
        logic [W-1:0] hb;
        int           changes;
        int           bad_state;

        repeat (3) @(negedge clk);
        check_eq("rst_pow", o_a_pow, '0);
        check_eq("rst_finished", W'(o_finished), '0);
        check_eq("rst_trans_start", W'(o_trans_start), '0);
        check_eq("rst_mult_start", W'(o_mult_start), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Done pulses while idle must be ignored.
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        check_eq("stray_idle", W'(dut.r_state), W'(rsa_pkg::S_IDLE));
        check_eq("stray_no_fin", W'(o_finished), '0);

        clear_counts();
        do_start(88, 7, 187);
        wait_finish("e7", 11);
        post_checks("e7", 11, OPS_E7);

        clear_counts();
        do_start(11, 23, 187);
        wait_finish("e23", 88);
        post_checks("e23", 88, OPS_E23);

        clear_counts();
        do_start(5, 0, 187);
        wait_finish("e0", 1);
        post_checks("e0", 1, OPS_E0);

        // Re-pulsed start mid-run with different operands is ignored.
        clear_counts();
        do_start(88, 7, 187);
        repeat (4) @(negedge clk);
        do_start(5, 0, 187);
        wait_finish("restart", 11);
        post_checks("restart", 11, OPS_E7);

        // Product unit stalls for 1000 cycles on the first multiply.
        clear_counts();
        mult_lat = 1000;
        do_start(88, 7, 187);
        wait_mult_start("hold");
        ha = o_mult_a;
        hb = o_mult_b;
        mult_lat = 1;
        check_eq("hold_a_is_one", ha, W'(1));
        check_eq("hold_b_is_trans", hb, mont_trans(88, 187));
        changes = 0;
        bad_state = 0;
        for (int i = 0; i < 998; i++) begin
            @(negedge clk);
            if (o_mult_a !== ha || o_mult_b !== hb) changes++;
            if (dut.r_state != rsa_pkg::S_MULT) bad_state++;
        end
        check_eq("hold_operand_changes", W'(changes), '0);
        check_eq("hold_state_mult", W'(bad_state), '0);
        check_eq("hold_no_new_start", W'(cnt_mult), W'(1));
        wait_finish("hold", 11);
        post_checks("hold", 11, OPS_E7);

        // Reset asserted while waiting in S_MULT.
        clear_counts();
        mult_lat = 5;
        do_start(88, 7, 187);
        wait_mult_start("rstmid");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_pow", o_a_pow, '0);
        check_eq("rstmid_finished", W'(o_finished), '0);
        check_eq("rstmid_mult_start", W'(o_mult_start), '0);
        check_eq("rstmid_trans_start", W'(o_trans_start), '0);
        check_eq("rstmid_state", W'(dut.r_state), W'(rsa_pkg::S_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("rstmid_no_fin", W'(cnt_fin), '0);
        mult_lat = 1;

        clear_counts();
        do_start(11, 23, 187);
        wait_finish("after_rst", 88);
        post_checks("after_rst", 88, OPS_E23);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
